edge_scheduler: RTL

Walks the configured edge list once per decoding iteration and streams the active edges to the decoder's processing units. It sits directly downstream of the configuration memory. It drives that memory's read port, absorbs its one-cycle registered read latency, and drops inactive or invalid edges. It reduces shifts modulo the lifting factor and tags layer boundaries. Output is a valid/ready stream with a 4-entry buffer, so backpressure never loses an in-flight read.

---
 rtl/edge_scheduler_pkg.sv | 37 +++
 rtl/edge_scheduler_if.sv | 37 +++
 rtl/edge_scheduler_sched_fifo.sv | 54 +++++
 rtl/edge_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_scheduler_pkg.sv
// Shared types and constants for the edge scheduler: FSM states, the edge record and shift reduction.
package edge_scheduler_pkg;

    localparam int unsigned SCHED_ITER_W = 6;
    localparam int unsigned IDX_W        = 8;
    localparam int unsigned SHIFT_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]        vn;
        logic [IDX_W-1:0]        cn;
        logic [SHIFT_W-1:0]      shift;
        logic                    layer_first;
        logic [SCHED_ITER_W-1:0] iter;
    } edge_rec_t;

    // Reduces a raw shift modulo z with at most one subtraction; MSB flags an out-of-range shift.
    function automatic logic [SHIFT_W:0] reduce_shift(input logic [SHIFT_W-1:0] shift,
                                                      input logic [SHIFT_W-1:0] z);
        logic [SHIFT_W-1:0] diff;
        diff = shift - z;
        if (shift < z) begin
            reduce_shift = {1'b0, shift};
        end else if (diff < z) begin
            reduce_shift = {1'b0, diff};
        end else begin
            reduce_shift = {1'b1, z - SHIFT_W'(1)};
        end
    endfunction

endpackage

// File: rtl/edge_scheduler_if.sv
// Configuration-memory read port plus the outgoing edge stream of the edge scheduler.
interface edge_scheduler_if
    import edge_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   cfg_read_addr;
    logic                    cfg_read_enable;
    logic [IDX_W-1:0]        cfg_src_vn_idx;
    logic [IDX_W-1:0]        cfg_dst_cn_idx;
    logic                    cfg_edge_active;
    logic [SHIFT_W-1:0]      cfg_shift_value;
    logic                    cfg_shift_valid;

    logic                    edge_valid;
    logic                    edge_ready;
    logic [IDX_W-1:0]        edge_vn;
    logic [IDX_W-1:0]        edge_cn;
    logic [SHIFT_W-1:0]      edge_shift;
    logic                    edge_layer_first;
    logic [SCHED_ITER_W-1:0] edge_iter;

    modport master (
        output cfg_read_addr, cfg_read_enable,
        input  cfg_src_vn_idx, cfg_dst_cn_idx, cfg_edge_active, cfg_shift_value, cfg_shift_valid,
        output edge_valid, edge_vn, edge_cn, edge_shift, edge_layer_first, edge_iter,
        input  edge_ready
    );

    modport slave (
        input  cfg_read_addr, cfg_read_enable,
        output cfg_src_vn_idx, cfg_dst_cn_idx, cfg_edge_active, cfg_shift_value, cfg_shift_valid,
        input  edge_valid, edge_vn, edge_cn, edge_shift, edge_layer_first, edge_iter,
        output edge_ready
    );

endinterface

// File: rtl/edge_scheduler_sched_fifo.sv
// Synchronous FIFO of edge records with flush, occupancy count and same-cycle push/pop.
module sched_fifo
    import edge_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  edge_rec_t                wdata,
    input  logic                     pop,
    output edge_rec_t                rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    edge_rec_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/edge_scheduler.sv
// Walks the configured edge list per iteration and streams active edges to the processing units.
// Optional statistics counters are built when EDGE_SCHED_STATS_EN is defined.
module edge_scheduler
    import edge_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_EDGES  = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     num_edges,
    input  logic [SCHED_ITER_W-1:0] num_iter,
    input  logic [SHIFT_W-1:0]      lifting_factor,
    input  logic                    cfg_ready,
    edge_scheduler_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             stat_emitted,
    output logic [15:0]             stat_skipped
);
    localparam int unsigned N_W   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_e            state;
    logic [N_W-1:0]          n_q;
    logic [SCHED_ITER_W-1:0] iters_q;
    logic [SHIFT_W-1:0]      z_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;
    logic [SCHED_ITER_W-1:0] next_iter_q;
    logic [ADDR_WIDTH-1:0]   read_addr_q;
    logic                    read_en_q;
    logic [SCHED_ITER_W-1:0] rd_iter_q;
    logic                    ret_q;
    logic [SCHED_ITER_W-1:0] ret_iter_q;
    logic                    have_wr_q;
    logic [IDX_W-1:0]        last_cn_q;
    logic [SCHED_ITER_W-1:0] last_iter_q;

    logic [N_W-1:0]          n_in;
    logic                    clamp_err;
    logic [SCHED_ITER_W-1:0] iters_in;
    logic                    accept;
    logic [N_W-1:0]          sel_n;
    logic [SCHED_ITER_W-1:0] sel_iters;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [SCHED_ITER_W-1:0] sel_iter;
    logic                    addr_end;
    logic                    last_read;
    logic                    credit_ok;
    logic                    issue;
    logic                    ret_keep;
    logic [SHIFT_W:0]        red;
    edge_rec_t               wr_rec;
    edge_rec_t               head;
    logic                    push;
    logic                    pop;
    logic                    drain_ok;
    logic [CNT_W-1:0]        fifo_count;

    // Run parameters as they will be latched by an accepted start.
    always_comb begin
        clamp_err = 32'(num_edges) > MAX_EDGES;
        n_in      = clamp_err ? N_W'(MAX_EDGES) : num_edges;
        iters_in  = (num_iter == '0) ? SCHED_ITER_W'(1) : num_iter;
    end

    assign accept = (state == ST_IDLE) && start && cfg_ready && !abort;

    // Read issue: the first read goes out on the accepting edge, so IDLE uses the fresh parameters.
    always_comb begin
        sel_n     = n_q;
        sel_iters = iters_q;
        sel_addr  = next_addr_q;
        sel_iter  = next_iter_q;
        if (state == ST_IDLE) begin
            sel_n     = n_in;
            sel_iters = iters_in;
            sel_addr  = '0;
            sel_iter  = '0;
        end
        addr_end  = (N_W'(sel_addr) == (sel_n - N_W'(1)));
        last_read = addr_end && (sel_iter == (sel_iters - SCHED_ITER_W'(1)));
        credit_ok = (32'(fifo_count) + 32'(read_en_q) + 32'(ret_q)) < FIFO_DEPTH;
        issue     = 1'b0;
        if (accept) begin
            issue = (n_in != '0);
        end else if ((state == ST_RUN) && !abort) begin
            issue = (n_q != '0) && credit_ok;
        end
    end

    // Return path: filter, reduce the shift and tag layer starts.
    always_comb begin
        ret_keep           = ret_q && bus.cfg_edge_active && bus.cfg_shift_valid;
        red                = reduce_shift(bus.cfg_shift_value, z_q);
        wr_rec.vn          = bus.cfg_src_vn_idx;
        wr_rec.cn          = bus.cfg_dst_cn_idx;
        wr_rec.shift       = red[SHIFT_W-1:0];
        wr_rec.layer_first = !have_wr_q || (ret_iter_q != last_iter_q)
                             || (bus.cfg_dst_cn_idx != last_cn_q);
        wr_rec.iter        = ret_iter_q;
        push               = ret_keep && !abort;
        pop                = bus.edge_valid && bus.edge_ready;
        drain_ok           = !read_en_q && !ret_q
                             && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    end

    sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    assign bus.cfg_read_addr    = read_addr_q;
    assign bus.cfg_read_enable  = read_en_q;
    assign bus.edge_valid       = (fifo_count != '0);
    assign bus.edge_vn          = head.vn;
    assign bus.edge_cn          = head.cn;
    assign bus.edge_shift       = head.shift;
    assign bus.edge_layer_first = head.layer_first;
    assign bus.edge_iter        = head.iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            n_q         <= '0;
            iters_q     <= '0;
            z_q         <= '0;
            next_addr_q <= '0;
            next_iter_q <= '0;
            read_addr_q <= '0;
            read_en_q   <= 1'b0;
            rd_iter_q   <= '0;
            ret_q       <= 1'b0;
            ret_iter_q  <= '0;
            have_wr_q   <= 1'b0;
            last_cn_q   <= '0;
            last_iter_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            read_en_q  <= issue;
            done       <= 1'b0;
            ret_q      <= read_en_q && !abort;
            ret_iter_q <= rd_iter_q;
            if (issue) begin
                read_addr_q <= sel_addr;
                rd_iter_q   <= sel_iter;
                next_addr_q <= addr_end ? '0 : (sel_addr + ADDR_WIDTH'(1));
                next_iter_q <= addr_end ? (sel_iter + SCHED_ITER_W'(1)) : sel_iter;
            end
            if (push) begin
                have_wr_q   <= 1'b1;
                last_cn_q   <= wr_rec.cn;
                last_iter_q <= ret_iter_q;
                if (red[SHIFT_W]) begin
                    err <= 1'b1;
                end
            end
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (!cfg_ready) begin
                                err <= 1'b1;
                            end else begin
                                n_q       <= n_in;
                                iters_q   <= iters_in;
                                z_q       <= lifting_factor;
                                have_wr_q <= 1'b0;
                                err       <= clamp_err;
                                busy      <= 1'b1;
                                state     <= (issue && last_read) ? ST_DRAIN : ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (n_q == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (issue && last_read) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_ok) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef EDGE_SCHED_STATS_EN
    logic skip;

    assign skip = ret_q && !ret_keep && !abort;

    // Saturating handshake and drop counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_emitted <= '0;
            stat_skipped <= '0;
        end else if (accept) begin
            stat_emitted <= '0;
            stat_skipped <= '0;
        end else begin
            if (pop && (stat_emitted != 16'hFFFF)) begin
                stat_emitted <= stat_emitted + 16'd1;
            end
            if (skip && (stat_skipped != 16'hFFFF)) begin
                stat_skipped <= stat_skipped + 16'd1;
            end
        end
    end
`else
    assign stat_emitted = '0;
    assign stat_skipped = '0;
`endif

endmodule
